// File: rtl/losowanie_multi.sv
// Lottery block: draws DRAWS distinct values 1..RANGE on button presses.
// Optional macro LOSOWANIE_DISPLAY_EN prints each new result in simulation.
module losowanie_multi #(
    parameter int WIDTH = 4,
    parameter int RANGE = 10,
    parameter int DRAWS = 3,
    localparam int CW   = $clog2(DRAWS + 1)
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             mouse_pressed,
    input  logic             restart,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [CW-1:0]    draw_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [RANGE-1:0]   drawn_q, drawn_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               press_q;
    logic               edge_w;
    logic               hit;

    assign edge_w = mouse_pressed & ~press_q;

    assign counter_d = (counter_q == WIDTH'(RANGE - 1)) ?
                       '0 : counter_q + WIDTH'(1);

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q   <= IDLE;
            counter_q <= '0;
            cand_q    <= '0;
            drawn_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            press_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            cand_q    <= cand_d;
            drawn_q   <= drawn_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            press_q   <= mouse_pressed;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        drawn_d  = drawn_q;
        result_d = result_q;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        done_d   = done_q;
        hit      = 1'b0;
        for (int i = 0; i < RANGE; i++)
            if (cand_q == WIDTH'(i))
                hit = drawn_q[i];
        // restart wins over any press or probe in flight
        if (restart) begin
            drawn_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (edge_w && !done_q) begin
                        cand_d  = counter_q;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (!hit) begin
                        for (int i = 0; i < RANGE; i++)
                            if (cand_q == WIDTH'(i))
                                drawn_d[i] = 1'b1;
                        result_d = cand_q + WIDTH'(1);
                        valid_d  = 1'b1;
                        cnt_d    = cnt_q + CW'(1);
                        done_d   = (cnt_q + CW'(1) == CW'(DRAWS));
                        state_d  = IDLE;
                    end else begin
                        cand_d = (cand_q == WIDTH'(RANGE - 1)) ?
                                 '0 : cand_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == SEARCH);
        result       = result_q;
        result_valid = valid_q;
        draw_count   = cnt_q;
        done         = done_q;
    end

`ifdef LOSOWANIE_DISPLAY_EN
    always_ff @(posedge clock) begin
        if (reset_ && valid_d)
            $display("wynik: %d", result_d);
    end
`else
`endif

endmodule
